// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared constants, state encoding and address table for the RTC read scheduler
package rtc_pkg;

  localparam int NUM_REGS = 9;
  localparam int IDX_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    REL,
    WAIT_VS,
    COMMIT,
    ERR
  } state_e;

  // RTC register address for each shadow slot, in read order
  function automatic logic [7:0] addr_of(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0:    addr_of = 8'h21;
      4'd1:    addr_of = 8'h22;
      4'd2:    addr_of = 8'h23;
      4'd3:    addr_of = 8'h24;
      4'd4:    addr_of = 8'h25;
      4'd5:    addr_of = 8'h26;
      4'd6:    addr_of = 8'h41;
      4'd7:    addr_of = 8'h42;
      4'd8:    addr_of = 8'h43;
      default: addr_of = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// rtl/frame_tick_counter.sv - vsync edge detector and modulo frame counter issuing refresh starts
module frame_tick_counter
  import rtc_pkg::*;
#(
  parameter int REFRESH_FRAMES = 30,
  parameter bit VS_ACTIVE      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vsync_i,
  input  logic enable_i,
  output logic frame_tick_o,
  output logic start_req_o
);

  localparam int CNT_W = (REFRESH_FRAMES > 1) ? $clog2(REFRESH_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_FRAMES - 1);

  logic             vs_sync_q;
  logic             vs_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             wrap;

  // Register vsync once, keep one more stage for edge detection; reset to the
  // active level so a vsync already in retrace at release gives no tick
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vs_sync_q <= VS_ACTIVE;
      vs_prev_q <= VS_ACTIVE;
    end else begin
      vs_sync_q <= vsync_i;
      vs_prev_q <= vs_sync_q;
    end
  end

  assign frame_tick_o = (vs_sync_q == VS_ACTIVE) && (vs_prev_q != VS_ACTIVE);
  assign wrap         = frame_tick_o && (cnt_q == LAST);
  assign start_req_o  = wrap && enable_i;

  // Count every tick regardless of scheduler activity, wrapping at the period
  always_comb begin
    cnt_d = cnt_q;
    if (frame_tick_o) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  // Frame counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rtc_read_scheduler.sv
// rtl/rtc_read_scheduler.sv - periodic RTC register reader with vsync-aligned atomic display commit
module rtc_read_scheduler
  import rtc_pkg::*;
#(
  parameter int REFRESH_FRAMES = 30,
  parameter int TIMEOUT        = 1023,
  parameter bit VS_ACTIVE      = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       enable,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic       rd_ack,
  input  logic [7:0] rd_data,
  output logic [7:0] R_Dia_Fecha,
  output logic [7:0] R_Mes_Fecha,
  output logic [7:0] R_Ano_Fecha,
  output logic [7:0] R_Hora_Hora,
  output logic [7:0] R_Hora_Minutos,
  output logic [7:0] R_Hora_Segundos,
  output logic [7:0] R_Cronometro_Hora,
  output logic [7:0] R_Cronometro_Minutos,
  output logic [7:0] R_Cronometro_Segundo,
  output logic       busy,
  output logic       update_pulse,
  output logic       timeout_err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             capture;
  logic             commit;
  logic             frame_tick;
  logic             start_req;

  logic [7:0] shadow_q [NUM_REGS];
  logic [7:0] disp_q   [NUM_REGS];

  frame_tick_counter #(
    .REFRESH_FRAMES(REFRESH_FRAMES),
    .VS_ACTIVE     (VS_ACTIVE)
  ) u_frame_tick (
    .clk_i       (clk),
    .rst_ni      (reset),
    .vsync_i     (vsync),
    .enable_i    (enable),
    .frame_tick_o(frame_tick),
    .start_req_o (start_req)
  );

  // Handshake sequencing, per-edge timeout and commit decision
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    capture = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        // starts are dropped rather than queued; never raise rd_req into a high ack
        if (start_req && !rd_ack) begin
          state_d = REQ;
          idx_d   = '0;
          tmo_d   = '0;
        end
      end
      REQ: begin
        if (rd_ack) begin
          capture = 1'b1;
          state_d = REL;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      REL: begin
        if (!rd_ack) begin
          if (idx_q == IDX_LAST) begin
            state_d = WAIT_VS;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = REQ;
            tmo_d   = '0;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_VS: begin
        // only a tick seen while already waiting counts, so the commit lands in retrace
        if (frame_tick) begin
          state_d = COMMIT;
          commit  = 1'b1;
          err_d   = 1'b0;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      ERR: begin
        if (!rd_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Shadow capture on each ack, and all-at-once copy to the display outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= 8'h00;
        disp_q[i]   <= 8'h00;
      end
    end else begin
      if (capture) begin
        shadow_q[idx_q] <= rd_data;
      end
      if (commit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          disp_q[i] <= shadow_q[i];
        end
      end
    end
  end

  assign rd_req       = (state_q == REQ);
  assign rd_addr      = rd_req ? addr_of(idx_q) : 8'h00;
  assign busy         = (state_q != IDLE);
  assign update_pulse = (state_q == COMMIT);
  assign timeout_err  = err_q;

  assign R_Hora_Segundos      = disp_q[0];
  assign R_Hora_Minutos       = disp_q[1];
  assign R_Hora_Hora          = disp_q[2];
  assign R_Dia_Fecha          = disp_q[3];
  assign R_Mes_Fecha          = disp_q[4];
  assign R_Ano_Fecha          = disp_q[5];
  assign R_Cronometro_Segundo = disp_q[6];
  assign R_Cronometro_Minutos = disp_q[7];
  assign R_Cronometro_Hora    = disp_q[8];

endmodule

// File: tb/tb_rtc_read_scheduler.sv
// tb/tb_rtc_read_scheduler.sv - scoreboard bench for the RTC read scheduler
module tb_rtc_read_scheduler;

  localparam int SEL_OUTS  = 0;
  localparam int SEL_REQ   = 1;
  localparam int SEL_BUSY  = 2;
  localparam int SEL_ERR   = 3;
  localparam int SEL_PULSE = 4;
  localparam int SEL_BOUND = 5;

  localparam logic [7:0] TB_ADDR [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

  logic       clk;
  logic       rst_n;
  logic       vsync;
  logic       enable;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic       rd_ack;
  logic [7:0] rd_data;
  logic [7:0] dia, mes, ano, hh, hm, hs, ch, cm, cs;
  logic       busy;
  logic       update_pulse;
  logic       timeout_err;
  logic [71:0] outs;

  int         checks;
  int         failures;
  int         resp_delay;
  logic [7:0] data_ofs;
  logic [7:0] block_addr;
  logic       tog_mode;

  typedef struct {
    string       name;
    int          sel;
    logic [71:0] exp;
  } pt_t;

  pt_t         pt_q [$];
  logic [7:0]  exp_addr [$];
  logic [71:0] exp_out [$];

  rtc_read_scheduler #(
    .REFRESH_FRAMES(2),
    .TIMEOUT       (15),
    .VS_ACTIVE     (1'b0)
  ) dut (
    .clk                 (clk),
    .reset               (rst_n),
    .vsync               (vsync),
    .enable              (enable),
    .rd_req              (rd_req),
    .rd_addr             (rd_addr),
    .rd_ack              (rd_ack),
    .rd_data             (rd_data),
    .R_Dia_Fecha         (dia),
    .R_Mes_Fecha         (mes),
    .R_Ano_Fecha         (ano),
    .R_Hora_Hora         (hh),
    .R_Hora_Minutos      (hm),
    .R_Hora_Segundos     (hs),
    .R_Cronometro_Hora   (ch),
    .R_Cronometro_Minutos(cm),
    .R_Cronometro_Segundo(cs),
    .busy                (busy),
    .update_pulse        (update_pulse),
    .timeout_err         (timeout_err)
  );

  assign outs = {hs, hm, hh, dia, mes, ano, cs, cm, ch};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] exp_outs(input logic [7:0] ofs);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v[71-8*i -: 8] = TB_ADDR[i] + ofs;
    return v;
  endfunction

  function automatic logic [71:0] obs(input int sel);
    case (sel)
      SEL_OUTS:  return outs;
      SEL_REQ:   return {71'd0, rd_req};
      SEL_BUSY:  return {71'd0, busy};
      SEL_ERR:   return {71'd0, timeout_err};
      SEL_PULSE: return {71'd0, update_pulse};
      default:   return 72'd1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic exp_now(input string nm, input int sel, input logic [71:0] exp);
    pt_t p;
    p.name = nm;
    p.sel  = sel;
    p.exp  = exp;
    pt_q.push_back(p);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b0;
    step(4);
    vsync = 1'b1;
    step(4);
  endtask

  task automatic push_addrs(input int n);
    for (int i = 0; i < n; i++) exp_addr.push_back(TB_ADDR[i]);
  endtask

  task automatic wait_reads(input int bound, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step(1);
      if (exp_addr.size() == 0 && !rd_req && !rd_ack) begin
        ok = 1'b1;
        break;
      end
    end
    step(1);
    if (!ok) exp_now(nm, SEL_BOUND, 72'd0);
  endtask

  task automatic wait_commit(input int bound, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (exp_out.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    if (!ok) exp_now(nm, SEL_BOUND, 72'd0);
  endtask

  // RTC responder: acks after resp_delay cycles with data = address + data_ofs
  initial begin
    int wcnt;
    wcnt    = 0;
    rd_ack  = 1'b0;
    rd_data = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (tog_mode) begin
        rd_ack = ~rd_ack;
      end else if (!rst_n) begin
        rd_ack = 1'b0;
        wcnt   = 0;
      end else if (rd_req && !rd_ack) begin
        if (rd_addr != block_addr) begin
          wcnt++;
          if (wcnt >= resp_delay) begin
            rd_ack  = 1'b1;
            rd_data = rd_addr + data_ofs;
            wcnt    = 0;
          end
        end
      end else if (!rd_req) begin
        rd_ack = 1'b0;
        wcnt   = 0;
      end
    end
  end

  // Monitor: point expectations, request scoreboard, commit scoreboard, handshake rules
  initial begin
    logic        prev_req, prev_ack, prev_pulse;
    logic [7:0]  prev_addr;
    logic [71:0] prev_outs;
    pt_t         p;
    checks     = 0;
    failures   = 0;
    prev_req   = 1'b0;
    prev_ack   = 1'b0;
    prev_pulse = 1'b0;
    prev_addr  = 8'h00;
    prev_outs  = '0;
    forever begin
      @(negedge clk);
      while (pt_q.size() > 0) begin
        p = pt_q.pop_front();
        chk(p.name, obs(p.sel), p.exp);
      end
      if (!rst_n) begin
        prev_req   = 1'b0;
        prev_ack   = 1'b0;
        prev_pulse = 1'b0;
        prev_outs  = '0;
      end else begin
        if (rd_req && !prev_req) begin
          if (exp_addr.size() > 0) chk("req_addr", {64'd0, rd_addr}, {64'd0, exp_addr.pop_front()});
          else chk("unexpected_req", {64'd0, rd_addr}, 72'd0);
          chk("req_rise_while_ack", {71'd0, prev_ack}, 72'd0);
        end
        if (rd_req && prev_req) chk("addr_stable", {64'd0, rd_addr}, {64'd0, prev_addr});
        if (update_pulse) begin
          chk("pulse_width", {71'd0, prev_pulse}, 72'd0);
          if (exp_out.size() > 0) chk("commit_outs", outs, exp_out.pop_front());
          else chk("unexpected_commit", outs, prev_outs);
        end else begin
          chk("outs_hold", outs, prev_outs);
        end
        prev_req   = rd_req;
        prev_ack   = rd_ack;
        prev_pulse = update_pulse;
        prev_addr  = rd_addr;
        prev_outs  = outs;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    rst_n      = 1'b0;
    vsync      = 1'b1;
    enable     = 1'b1;
    tog_mode   = 1'b1;
    resp_delay = 3;
    data_ofs   = 8'h01;
    block_addr = 8'hFF;

    // reset with ack and vsync toggling
    step(2);
    vsync = 1'b0;
    step(2);
    vsync = 1'b1;
    step(2);
    exp_now("rst_outs", SEL_OUTS, 72'd0);
    exp_now("rst_req", SEL_REQ, 72'd0);
    exp_now("rst_busy", SEL_BUSY, 72'd0);
    exp_now("rst_err", SEL_ERR, 72'd0);
    exp_now("rst_pulse", SEL_PULSE, 72'd0);
    tog_mode = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);

    // first tick after reset must not start a sequence
    pulse_vsync();
    step(10);
    exp_now("no_start_tick1_busy", SEL_BUSY, 72'd0);
    exp_now("no_start_tick1_req", SEL_REQ, 72'd0);

    // normal sequence, commit on the following tick
    push_addrs(9);
    pulse_vsync();
    wait_reads(200, "seq1_reads_bound");
    exp_now("outs_before_tick", SEL_OUTS, 72'd0);
    exp_out.push_back(72'h22_23_24_25_26_27_42_43_44);
    pulse_vsync();
    wait_commit(40, "seq1_commit_bound");

    // tearing guard: reads done, vsync withheld for 500 cycles
    data_ofs = 8'h02;
    push_addrs(9);
    pulse_vsync();
    wait_reads(200, "seq2_reads_bound");
    step(500);
    exp_now("outs_after_500", SEL_OUTS, exp_outs(8'h01));
    exp_out.push_back(exp_outs(8'h02));
    pulse_vsync();
    wait_commit(40, "seq2_commit_bound");

    // timeout on address 24
    data_ofs   = 8'h03;
    block_addr = 8'h24;
    push_addrs(4);
    pulse_vsync();
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (rd_req && rd_addr == 8'h24) begin
          found = 1'b1;
          break;
        end
        step(1);
      end
      if (!found) exp_now("tmo_req24_bound", SEL_BOUND, 72'd0);
    end
    step(14);
    exp_now("tmo_req_held", SEL_REQ, 72'd1);
    step(1);
    exp_now("tmo_req_dropped", SEL_REQ, 72'd0);
    exp_now("tmo_err_set", SEL_ERR, 72'd1);
    exp_now("tmo_busy_in_err", SEL_BUSY, 72'd1);
    step(5);
    exp_now("tmo_err_sticky", SEL_ERR, 72'd1);
    exp_now("tmo_idle", SEL_BUSY, 72'd0);
    exp_now("tmo_outs_kept", SEL_OUTS, exp_outs(8'h02));

    // recovery sequence commits and clears the error
    block_addr = 8'hFF;
    data_ofs   = 8'h04;
    push_addrs(9);
    pulse_vsync();
    pulse_vsync();
    wait_reads(200, "seq4_reads_bound");
    exp_now("err_until_commit", SEL_ERR, 72'd1);
    exp_out.push_back(exp_outs(8'h04));
    pulse_vsync();
    wait_commit(40, "seq4_commit_bound");
    exp_now("err_cleared", SEL_ERR, 72'd0);

    // long responder: ticks while busy start nothing, enable drop lets it finish
    resp_delay = 10;
    data_ofs   = 8'h05;
    push_addrs(9);
    exp_out.push_back(exp_outs(8'h05));
    for (int k = 0; k < 30; k++) begin
      pulse_vsync();
      if (k == 6) enable = 1'b0;
    end
    wait_commit(1, "seq5_commit_bound");
    exp_now("seq5_idle", SEL_BUSY, 72'd0);
    exp_now("seq5_no_req", SEL_REQ, 72'd0);

    // asynchronous reset mid-handshake
    enable   = 1'b1;
    data_ofs = 8'h06;
    push_addrs(9);
    for (int k = 0; k < 3; k++) begin
      pulse_vsync();
      if (busy) break;
    end
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (rd_req) begin
          found = 1'b1;
          break;
        end
        step(1);
      end
      if (!found) exp_now("areset_req_bound", SEL_BOUND, 72'd0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_now("areset_req", SEL_REQ, 72'd0);
    exp_now("areset_busy", SEL_BUSY, 72'd0);
    exp_now("areset_outs", SEL_OUTS, 72'd0);
    exp_addr.delete();
    step(3);
    rst_n = 1'b1;
    step(5);
    exp_now("post_areset_idle", SEL_BUSY, 72'd0);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtc_read_scheduler.md
Name: rtc_read_scheduler

Overview:
- Sequences periodic reads of the nine RTC registers (date, time, chronometer) over a four-phase read handshake into shadow registers.
- Commits all nine values to the display generator's inputs in one cycle, at the start of vertical sync, so a frame never shows a mixed old/new time.
- Sits between the RTC bus master and the pixel generator, clocked by the divided pixel clock.

Parameters:
- REFRESH_FRAMES, 30, frame ticks between read sequences (1..255).
- TIMEOUT, 1023, max clk cycles waited for each ack edge before aborting.
- VS_ACTIVE, 0, vsync level that marks retrace.

Ports:
- clk  in  1  pixel clock, rising edge.
- reset  in  1  asynchronous, active-low.
- vsync  in  1  from sync generator, same clock domain.
- enable  in  1  periodic refresh enable.
- rd_req  out  1  read request, four-phase.
- rd_addr  out  8  RTC register address, valid while rd_req=1.
- rd_ack  in  1  read acknowledge.
- rd_data  in  8  BCD data, valid while rd_ack=1.
- R_Dia_Fecha, R_Mes_Fecha, R_Ano_Fecha, R_Hora_Hora, R_Hora_Minutos, R_Hora_Segundos, R_Cronometro_Hora, R_Cronometro_Minutos, R_Cronometro_Segundo  out  8 each  committed display values.
- busy  out  1  sequence in progress (any state except IDLE).
- update_pulse  out  1  one-cycle pulse on commit.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset (async, reset=0): all nine outputs 8'h00; rd_req, busy, update_pulse, timeout_err = 0; rd_addr = 8'h00; FSM in IDLE; frame counter = 0; shadow registers = 0.
- Frame tick: one cycle, when vsync (registered once) goes from !VS_ACTIVE to VS_ACTIVE.
- Frame counter increments on every tick, including while busy, and wraps at REFRESH_FRAMES-1.
  - A start is requested when the counter wraps with enable=1.
  - A start requested while busy is dropped, not queued.
- FSM states:
  - IDLE -> REQ on start request; index = 0.
  - REQ: rd_req=1, rd_addr=ADDR_TABLE[index]. Stay until rd_ack=1. In the ack cycle, capture rd_data into shadow[index] and go to REL.
  - REL: rd_req=0. Stay until rd_ack=0.
    - index<8: index+1, go to REQ.
    - index=8: go to WAIT_VS.
  - WAIT_VS: wait for the next frame tick. A tick in the same cycle WAIT_VS is entered is not used.
  - COMMIT: one cycle. Copy all shadows to the outputs; update_pulse=1; clear timeout_err; go to IDLE.
  - Earliest sequence: REQ (ack same cycle) -> REL -> ..., two cycles per register minimum.
- Timeout:
  - A cycle counter resets on entry to REQ or REL.
  - If it reaches TIMEOUT without the awaited ack edge, go to ERR.
  - ERR: rd_req=0, timeout_err=1, no commit (outputs keep previous values). Return to IDLE when rd_ack=0.
- Handshake rules:
  - rd_addr is stable whenever rd_req=1.
  - rd_req never rises while rd_ack=1.
- enable=0 mid-sequence does not abort the sequence; it only blocks new starts.
- Reset mid-sequence: immediate return to reset values; rd_req drops asynchronously.
- Output-to-index mapping (index 0..8): Hora_Segundos, Hora_Minutos, Hora_Hora, Dia_Fecha, Mes_Fecha, Ano_Fecha, Cronometro_Segundo, Cronometro_Minutos, Cronometro_Hora.
- Data is passed through unmodified; no BCD checking.

Decomposition:
- Shared package rtc_pkg holds:
  - ADDR_TABLE constants: 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43.
  - NUM_REGS = 9.
  - FSM state encodings: IDLE, REQ, REL, WAIT_VS, COMMIT, ERR.
- One natural sub-module: frame_tick_counter (vsync edge detect plus modulo-REFRESH_FRAMES counter, emits start request).
- Shadow/commit register file stays inline.

Test Plan:
- Reset: hold reset=0 with rd_ack toggling -> all outputs 00, rd_req=0, busy=0; after release, no request before the REFRESH_FRAMES-th tick.
- Normal sequence: REFRESH_FRAMES=2, enable=1, responder acks after 3 cycles returning data = address+1 -> addresses 21..26, 41..43 issued in order; outputs unchanged until the next tick; then one-cycle update_pulse and Hora_Segundos=22, Cronometro_Hora=44.
- Tearing guard: complete the reads, then delay vsync 500 cycles -> outputs hold old values for the whole 500 cycles; all nine change in the same cycle as update_pulse.
- Timeout: TIMEOUT=15, responder never acks address 24 -> rd_req drops 15 cycles after REQ entry, timeout_err=1, outputs unchanged; next successful sequence commits and clears timeout_err.
- Overlap/enable: responder with 1000-cycle ack, REFRESH_FRAMES=1 -> ticks during busy start no new sequence; enable=0 mid-sequence -> current sequence commits, no further rd_req.
- Async reset mid-handshake: reset=0 while rd_req=1 -> rd_req=0 before the next clk edge; outputs 00.
